// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every handshake/bus signal around the shared memory port:
//   the instruction-fetch requester (i_*), the memory-stage requester (d_*)
//   and the unified memory (mem_*).
//
//   Modports:
//     master : the arbiter's view -- drives acks, read data back to the
//              requesters and the registered memory request.
//     slave  : the environment's view (pipeline stages plus memory model) --
//              drives requests, memory ack and memory read data.
//
//   Signals:
//     i_req, i_addr                      fetch request (read-only)
//     i_ack, i_rdata                     fetch completion / data
//     d_req, d_we, d_addr, d_wdata,
//     d_wstrb                            load/store request
//     d_ack, d_rdata                     load/store completion / data
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_wstrb               registered memory request
//     mem_ack, mem_rdata                 memory completion / read data
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the CPU's single memory port between the instruction-fetch stage
//   and the memory stage. One requester is granted at a time; the granted
//   request is latched into registered mem_* outputs and the memory ack /
//   read data are routed back to the granted requester with no added latency.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset (aborts any transfer in flight)
//     bus  : mem_port_arbiter_if.master (requester and memory signals)
//
//   Optional feature (compile-time macro ARB_FAIR_EN):
//     defined   : simultaneous requests alternate via a last-grant register
//     undefined : the data port always wins simultaneous requests
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;

  logic grant_i;
  logic grant_d;

  // ---------------------------------------------------------------------------
  // Grant selection (only acted on in IDLE)
  // ---------------------------------------------------------------------------
`ifdef ARB_FAIR_EN
  // 1 = data port was granted last, 0 = fetch port (reset value).
  logic last_grant_d_q;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (bus.d_req && bus.i_req) begin
      grant_d = !last_grant_d_q;
      grant_i =  last_grant_d_q;
    end else begin
      grant_d = bus.d_req;
      grant_i = bus.i_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_d_q <= 1'b0;
    end else if (state_q == IDLE && (grant_d || grant_i)) begin
      last_grant_d_q <= grant_d;
    end
  end
`else
  // Data port drains first so the MEM stage is never starved by fetch.
  always_comb begin
    grant_d = bus.d_req;
    grant_i = bus.i_req && !bus.d_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            // Byte enables are meaningless on loads; keep them all-zero.
            mem_wstrb_q <= bus.d_we ? bus.d_wstrb : '0;
          end else if (grant_i) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // All mem_* hold their values until the memory completes.
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  // Acks are combinational so completion reaches the requester in the same
  // cycle as mem_ack; a stray mem_ack while IDLE produces nothing.
  assign bus.i_ack   = bus.mem_ack && (state_q == BUSY_I);
  assign bus.d_ack   = bus.mem_ack && (state_q == BUSY_D);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the CPU's single memory port between the instruction-fetch stage (read-only) and the memory stage (load/store). It grants one requester at a time, latches the granted request into registered memory-side outputs, and routes the memory acknowledge and read data back to the granted requester. It sits between the pipeline's IF/MEM stages and the unified memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- i_req  input  1  fetch request valid; held until i_ack
- i_addr  input  ADDR_W  fetch address
- i_ack  output  1  fetch handshake complete; i_rdata valid this cycle
- i_rdata  output  DATA_W  fetch data
- d_req  input  1  data request valid; held until d_ack
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_wstrb  input  DATA_W/8  byte enables for stores
- d_ack  output  1  data handshake complete; d_rdata valid on loads
- d_rdata  output  DATA_W  load data
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  address
- mem_wdata  output  DATA_W  write data
- mem_wstrb  output  DATA_W/8  byte enables (all zero on reads)
- mem_ack  input  1  memory completion; mem_rdata valid this cycle on reads
- mem_rdata  input  DATA_W  read data

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if no request, stay. If only one request, grant it. If both: priority per Configuration. On grant, register mem_we/addr/wdata/wstrb from granted port (fetch: we=0, wstrb=0, wdata=0) and set mem_req=1.
- BUSY_x: hold all mem_* outputs stable. When mem_ack=1: assert x_ack combinationally (mem_ack && state==BUSY_x), pass mem_rdata to x_rdata, clear mem_req, next state IDLE.
- i_rdata/d_rdata are pass-through of mem_rdata; meaningful only while the respective ack is high.
- mem_ack in IDLE is ignored; no ack generated.
- Requester dropping req while BUSY: protocol violation; arbiter still completes and pulses ack.
- Requests are never queued; a port not granted simply keeps req asserted.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, i_ack 0, d_ack 0, last-grant register = fetch.
- Request seen at edge ending cycle N -> mem_req high from cycle N+1.
- mem_ack in cycle M -> x_ack high in cycle M (zero added latency); minimum req-to-ack latency 1 cycle.
- After ack, one IDLE cycle precedes the next grant: max throughput one transfer per 2 cycles + memory wait.
- Requester samples ack at the same edge the arbiter returns to IDLE; it may present a new request (same port) in the following cycle.
- Reset mid-BUSY: transaction abandoned immediately, mem_req drops asynchronously, no ack issued; memory model must tolerate abort.

## Configuration
- ARB_FAIR_EN defined: on simultaneous requests in IDLE, grant the port not granted last (round-robin via last-grant register, updated on every grant).
- ARB_FAIR_EN undefined: data port always wins simultaneous requests (drains MEM stage first); last-grant register not implemented.

## Test plan
- Single fetch: i_req=1, i_addr=0x100, memory acks 2 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x100, mem_we=0, mem_wstrb=0; i_ack one cycle with i_rdata=0xDEADBEEF; d_ack never.
- Store: d_req=1, d_we=1, d_addr=0x204, d_wdata=0x12345678, d_wstrb=4'b0011 -> mem outputs match exactly, stable until mem_ack; d_ack same cycle as mem_ack.
- Simultaneous i_req/d_req held for 4 transfers, memory acks in 1 cycle -> without ARB_FAIR_EN: D,D,D,D; with ARB_FAIR_EN: D,I,D,I (last-grant starts at fetch).
- Back-to-back fetches with zero-wait memory -> acks every 2 cycles, mem_req low exactly one cycle between.
- Async rst pulse mid-BUSY_D -> mem_req and all mem_* return to 0 same cycle, no d_ack; after release, held d_req regranted within 1 cycle.
- Spurious mem_ack in IDLE -> no i_ack/d_ack, state remains IDLE.
